// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath constants and types
package mips_pkg;

  localparam int DW_DEFAULT   = 32;
  localparam int REG_DEPTH    = 32;
  localparam int REG_AW       = 5;
  localparam int ZERO_REG_IDX = 0;

  typedef logic [DW_DEFAULT-1:0] word_t;
  typedef logic [REG_AW-1:0]     reg_addr_t;

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one read port: storage mux, write bypass, busy masking
module regfile_rd_port
  import mips_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int DEPTH    = REG_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [DW-1:0]    regs [DEPTH],
  input  logic [DEPTH-1:0] busy,
  input  logic [AW-1:0]    rd_addr,
  input  logic             wr_valid,
  input  logic [AW-1:0]    waddr,
  input  logic [DW-1:0]    wdata,
  input  logic             set_valid,
  input  logic [AW-1:0]    busy_addr,
  output logic [DW-1:0]    rd_data,
  output logic             rd_busy
);

  logic addr_ok;
  logic is_zero;
  logic wr_hit;
  logic set_hit;

  // Classify the address and detect same-cycle writer/producer hits.
  always_comb begin
    addr_ok = int'(rd_addr) < DEPTH;
    is_zero = (ZERO_REG != 0) && (rd_addr == AW'(ZERO_REG_IDX));
    wr_hit  = (BYPASS != 0) && wr_valid && (waddr == rd_addr);
    set_hit = set_valid && (busy_addr == rd_addr);
  end

  // Select data and busy flag; a forwarded write retires the pending producer
  // unless a new producer is being issued to the same register right now.
  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (addr_ok && !is_zero) begin
      if (wr_hit) begin
        rd_data = wdata;
        rd_busy = set_hit ? busy[rd_addr] : 1'b0;
      end else begin
        rd_data = regs[rd_addr];
        rd_busy = busy[rd_addr];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with busy scoreboard
module regfile_mp
  import mips_pkg::*;
#(
  parameter int DW         = DW_DEFAULT,
  parameter int DEPTH      = REG_DEPTH,
  parameter int AW         = $clog2(DEPTH),
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1,
  parameter int INIT_INDEX = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [DW-1:0]        wdata,
  input  logic                 busy_set,
  input  logic [AW-1:0]        busy_addr,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*DW-1:0] rd_data,
  output logic [NUM_RD-1:0]    rd_busy
);

  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             wr_valid;
  logic             set_valid;

  // A write or busy-set only counts for an in-range, writable register and
  // never while reset is asserted, so reset also hides any bypass.
  always_comb begin
    wr_valid  = rst_n && we && (int'(waddr) < DEPTH) &&
                !((ZERO_REG != 0) && (waddr == AW'(ZERO_REG_IDX)));
    set_valid = rst_n && busy_set && (int'(busy_addr) < DEPTH) &&
                !((ZERO_REG != 0) && (busy_addr == AW'(ZERO_REG_IDX)));
  end

  // Storage: reset to index or zero, then accept qualified writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= (INIT_INDEX != 0) ? DW'(i) : '0;
      end
    end else if (wr_valid) begin
      regs[waddr] <= wdata;
    end
  end

  // Scoreboard: a write clears its register, a set marks one; the set is
  // applied last so a newly issued producer wins over a retiring one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (wr_valid) busy[waddr] <= 1'b0;
      if (set_valid) busy[busy_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(
      .DW       (DW),
      .DEPTH    (DEPTH),
      .AW       (AW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_port (
      .regs      (regs),
      .busy      (busy),
      .rd_addr   (rd_addr[k*AW +: AW]),
      .wr_valid  (wr_valid),
      .waddr     (waddr),
      .wdata     (wdata),
      .set_valid (set_valid),
      .busy_addr (busy_addr),
      .rd_data   (rd_data[k*DW +: DW]),
      .rd_busy   (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for two regfile_mp configurations
module tb_regfile_mp;

  typedef struct packed {
    logic [1:0][31:0] ad;
    logic [1:0]       ab;
    logic [2:0][15:0] bd;
    logic [2:0]       bb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic        busy_set = 1'b0;
  logic [4:0]  waddr = '0;
  logic [4:0]  busy_addr = '0;
  logic [31:0] wdata_a = '0;
  logic [15:0] wdata_b = '0;
  logic [9:0]  a_rd_addr = '0;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [14:0] b_rd_addr = '0;
  logic [47:0] b_rd_data;
  logic [2:0]  b_rd_busy;

  always #5 clk = ~clk;

  regfile_mp u_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata_a),
    .busy_set(busy_set), .busy_addr(busy_addr), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .rd_busy(a_rd_busy)
  );

  regfile_mp #(.DW(16), .DEPTH(24), .NUM_RD(3), .BYPASS(0), .INIT_INDEX(1)) u_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata_b),
    .busy_set(busy_set), .busy_addr(busy_addr), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_busy(b_rd_busy)
  );

  // Reference model: config 0 = u_a, config 1 = u_b.
  int          dep  [2] = '{32, 24};
  bit          byp  [2] = '{1'b1, 1'b0};
  bit          init [2] = '{1'b0, 1'b1};
  logic [31:0] m_regs [2][32];
  bit          m_busy [2][32];

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  bit          p_valid = 0, p_rst = 0, p_we = 0, p_bs = 0;
  int          p_wa = 0, p_ba = 0;
  logic [31:0] p_wd = '0;

  function automatic logic [31:0] mask(int c);
    return (c == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic bit writable(int c, int a);
    return (a != 0) && (a < dep[c]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 32; i++) begin
        m_regs[c][i] = init[c] ? (i & mask(c)) : 32'd0;
        m_busy[c][i] = 1'b0;
      end
  endtask

  task automatic commit();
    if (p_valid && p_rst)
      for (int c = 0; c < 2; c++) begin
        if (p_we && writable(c, p_wa)) begin
          m_regs[c][p_wa] = p_wd & mask(c);
          m_busy[c][p_wa] = 1'b0;
        end
        if (p_bs && writable(c, p_ba)) m_busy[c][p_ba] = 1'b1;
      end
  endtask

  task automatic predict(input int c, input int ra, input bit rst, input bit w,
                         input int wa, input logic [31:0] wd, input bit s,
                         input int sa, output logic [31:0] d, output bit b);
    d = 32'd0;
    b = 1'b0;
    if (ra < dep[c] && ra != 0) begin
      d = m_regs[c][ra];
      b = m_busy[c][ra];
      if (byp[c] && rst && w && writable(c, wa) && wa == ra) begin
        d = wd & mask(c);
        if (!(s && writable(c, sa) && sa == ra)) b = 1'b0;
      end
    end
  endtask

  task automatic step(input bit rst, input bit w, input int wa, input logic [31:0] wd,
                      input bit s, input int sa, input int r0, input int r1, input int r2);
    exp_t        e;
    logic [31:0] d;
    bit          b;
    int          ra [3];
    @(posedge clk);
    #1;
    commit();
    if (!rst) model_reset();
    ra = '{r0, r1, r2};
    rst_n     = rst;
    we        = w;
    waddr     = wa[4:0];
    wdata_a   = wd;
    wdata_b   = wd[15:0];
    busy_set  = s;
    busy_addr = sa[4:0];
    a_rd_addr = {r1[4:0], r0[4:0]};
    b_rd_addr = {r2[4:0], r1[4:0], r0[4:0]};
    for (int k = 0; k < 2; k++) begin
      predict(0, ra[k], rst, w, wa, wd, s, sa, d, b);
      e.ad[k] = d;
      e.ab[k] = b;
    end
    for (int k = 0; k < 3; k++) begin
      predict(1, ra[k], rst, w, wa, wd, s, sa, d, b);
      e.bd[k] = d[15:0];
      e.bb[k] = b;
    end
    sb.push_back(e);
    p_valid = 1; p_rst = rst; p_we = w; p_wa = wa; p_wd = wd; p_bs = s; p_ba = sa;
  endtask

  // Monitor: outputs are settled mid-cycle; pop one expectation per cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (a_rd_data[k*32 +: 32] !== e.ad[k]) begin
          n_fail++;
          $display("FAIL a_data port%0d: got %h expected %h", k, a_rd_data[k*32 +: 32], e.ad[k]);
        end
        n_checks++;
        if (a_rd_busy[k] !== e.ab[k]) begin
          n_fail++;
          $display("FAIL a_busy port%0d: got %b expected %b", k, a_rd_busy[k], e.ab[k]);
        end
      end
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (b_rd_data[k*16 +: 16] !== e.bd[k]) begin
          n_fail++;
          $display("FAIL b_data port%0d: got %h expected %h", k, b_rd_data[k*16 +: 16], e.bd[k]);
        end
        n_checks++;
        if (b_rd_busy[k] !== e.bb[k]) begin
          n_fail++;
          $display("FAIL b_busy port%0d: got %b expected %b", k, b_rd_busy[k], e.bb[k]);
        end
      end
    end
  end

  initial begin
    model_reset();
    // reset state, write during reset dropped
    step(0, 1, 7, 32'h1111_1111, 1, 7, 5, 31, 0);
    step(1, 0, 0, 0, 0, 0, 5, 31, 0);
    // write then read, bypass vs no bypass
    step(1, 1, 7, 32'hDEAD_BEEF, 0, 0, 7, 7, 7);
    step(1, 0, 0, 0, 0, 0, 7, 7, 7);
    // zero register
    step(1, 1, 0, 32'h1234_5678, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // scoreboard set then clear by write
    step(1, 0, 0, 0, 1, 9, 9, 9, 9);
    step(1, 0, 0, 0, 0, 0, 9, 9, 9);
    step(1, 1, 9, 32'h0000_00A5, 0, 0, 9, 9, 9);
    step(1, 0, 0, 0, 0, 0, 9, 9, 9);
    // simultaneous set and write to one address
    step(1, 1, 12, 32'h0000_0055, 1, 12, 12, 12, 12);
    step(1, 0, 0, 0, 0, 0, 12, 12, 12);
    // out-of-range write/read on the 24-deep instance
    step(1, 1, 25, 32'h0000_BEEF, 1, 25, 25, 25, 25);
    step(1, 0, 0, 0, 0, 0, 25, 25, 25);
    // shared addresses across ports
    step(1, 1, 3, 32'h0000_CAFE, 0, 0, 3, 3, 23);
    step(1, 0, 0, 0, 0, 0, 3, 3, 23);
    // reset asserted during a write and busy set
    step(1, 0, 0, 0, 1, 5, 5, 3, 23);
    step(0, 1, 5, 32'h0000_FFFF, 1, 5, 5, 3, 23);
    step(1, 0, 0, 0, 0, 0, 5, 3, 23);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) != 0), $urandom_range(0, 1), $urandom_range(0, 31), $urandom,
           ($urandom_range(0, 2) == 0), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
    end
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
